// File: rtl/cfg_stream_loader_pkg.sv
// cfg_stream_loader_pkg
//   Shared definitions for the configuration stream loader: parser state
//   encoding, error codes and the default charset terminator byte.
package cfg_stream_loader_pkg;

   typedef enum logic [2:0] {
      ST_CHARSET = 3'd0,
      ST_SEED    = 3'd1,
      ST_GOAL    = 3'd2,
      ST_DONE    = 3'd3,
      ST_ERROR   = 3'd4
   } state_e;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_EMPTY    = 2'b01;
   localparam logic [1:0] ERR_OVERFLOW = 2'b10;

   localparam logic [7:0] DEF_TERM_CHAR = 8'h0A;

endpackage

// File: rtl/cfg_word_assembler.sv
// cfg_word_assembler
//   Collects NBYTES bytes into a word, first byte ending up as the MSB.
//   Ports:
//     clk, rst  - clock, asynchronous active-high reset
//     clr       - zero the byte counter (word contents are kept)
//     load      - shift byte_in into the word
//     byte_in   - incoming byte
//     word      - assembled word
//     last      - combinational: the current load is the final byte
module cfg_word_assembler
   import cfg_stream_loader_pkg::*;
#(
   parameter int NBYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  load,
   input  logic [7:0]            byte_in,
   output logic [NBYTES*8-1:0]   word,
   output logic                  last
);

   localparam int CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   logic [NBYTES*8-1:0] word_q, word_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   // One byte wider than the word so the shift works for NBYTES == 1 too.
   logic [NBYTES*8+7:0] shifted;

   assign last    = load && (cnt_q == CNT_W'(NBYTES - 1));
   assign shifted = {word_q, byte_in};
   assign word    = word_q;

   always_comb begin
      word_d = word_q;
      cnt_d  = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (load) begin
         word_d = shifted[NBYTES*8-1:0];
         // Wrap after the last byte so the next job starts from zero.
         cnt_d  = last ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else begin
         word_q <= word_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/cfg_stream_loader.sv
// cfg_stream_loader
//   Parses the host byte stream into NUM_POS terminated charsets, a seed word
//   and a goal word. Charset characters go out through a table write port.
//   Ports:
//     fpgaclk, reset     - clock, asynchronous active-high reset
//     rx_dv, rx_byte     - received byte strobe and data
//     rearm              - drop the current job and start a new parse
//     wr_en/pos/idx/char - charset table write port (registered pulse)
//     len_flat           - per-position charset lengths
//     seed, goal         - assembled words, first byte is MSB
//     cfg_done, cfg_err  - job complete / parse error (levels)
//     err_code           - 01 empty charset, 10 overflow, 00 none
module cfg_stream_loader
   import cfg_stream_loader_pkg::*;
#(
   parameter int         NUM_POS    = 8,
   parameter int         MAX_CHARS  = 64,
   parameter int         SEED_BYTES = 4,
   parameter int         GOAL_BYTES = 4,
   parameter logic [7:0] TERM_CHAR  = DEF_TERM_CHAR,
   localparam int        LEN_W      = $clog2(MAX_CHARS + 1),
   localparam int        POS_W      = (NUM_POS > 1) ? $clog2(NUM_POS) : 1
) (
   input  logic                       fpgaclk,
   input  logic                       reset,
   input  logic                       rx_dv,
   input  logic [7:0]                 rx_byte,
   input  logic                       rearm,
   output logic                       wr_en,
   output logic [POS_W-1:0]           wr_pos,
   output logic [LEN_W-1:0]           wr_idx,
   output logic [7:0]                 wr_char,
   output logic [NUM_POS*LEN_W-1:0]   len_flat,
   output logic [SEED_BYTES*8-1:0]    seed,
   output logic [GOAL_BYTES*8-1:0]    goal,
   output logic                       cfg_done,
   output logic                       cfg_err,
   output logic [1:0]                 err_code
);

   state_e                           state_q, state_d;
   logic [POS_W-1:0]                 pos_q, pos_d;
   logic [LEN_W-1:0]                 idx_q, idx_d;
   logic [NUM_POS-1:0][LEN_W-1:0]    len_q, len_d;
   logic                             wr_en_q, wr_en_d;
   logic [POS_W-1:0]                 wr_pos_q, wr_pos_d;
   logic [LEN_W-1:0]                 wr_idx_q, wr_idx_d;
   logic [7:0]                       wr_char_q, wr_char_d;
   logic                             done_q, done_d;
   logic                             err_q, err_d;
   logic [1:0]                       code_q, code_d;

   logic seed_load, goal_load, asm_clr, seed_last, goal_last;

   always_comb begin
      state_d   = state_q;
      pos_d     = pos_q;
      idx_d     = idx_q;
      len_d     = len_q;
      wr_en_d   = 1'b0;
      wr_pos_d  = wr_pos_q;
      wr_idx_d  = wr_idx_q;
      wr_char_d = wr_char_q;
      done_d    = done_q;
      err_d     = err_q;
      code_d    = code_q;
      seed_load = 1'b0;
      goal_load = 1'b0;
      asm_clr   = 1'b0;
      // rearm takes priority over a coincident byte, which is dropped.
      if (rearm) begin
         state_d = ST_CHARSET;
         pos_d   = '0;
         idx_d   = '0;
         len_d   = '0;
         done_d  = 1'b0;
         err_d   = 1'b0;
         code_d  = ERR_NONE;
         asm_clr = 1'b1;
      end else if (rx_dv) begin
         case (state_q)
            ST_CHARSET: begin
               if (rx_byte != TERM_CHAR) begin
                  if (idx_q < LEN_W'(MAX_CHARS)) begin
                     wr_en_d   = 1'b1;
                     wr_pos_d  = pos_q;
                     wr_idx_d  = idx_q;
                     wr_char_d = rx_byte;
                     idx_d     = idx_q + 1'b1;
                  end else begin
                     state_d = ST_ERROR;
                     err_d   = 1'b1;
                     code_d  = ERR_OVERFLOW;
                  end
               end else if (idx_q == '0) begin
                  state_d = ST_ERROR;
                  err_d   = 1'b1;
                  code_d  = ERR_EMPTY;
               end else begin
                  len_d[pos_q] = idx_q;
                  idx_d        = '0;
                  if (pos_q == POS_W'(NUM_POS - 1)) state_d = ST_SEED;
                  else                              pos_d   = pos_q + 1'b1;
               end
            end
            ST_SEED: begin
               seed_load = 1'b1;
               if (seed_last) state_d = ST_GOAL;
            end
            ST_GOAL: begin
               goal_load = 1'b1;
               if (goal_last) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end
            end
            default: ;   // DONE / ERROR ignore incoming bytes
         endcase
      end
   end

   always_ff @(posedge fpgaclk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_CHARSET;
         pos_q     <= '0;
         idx_q     <= '0;
         len_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_pos_q  <= '0;
         wr_idx_q  <= '0;
         wr_char_q <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         code_q    <= ERR_NONE;
      end else begin
         state_q   <= state_d;
         pos_q     <= pos_d;
         idx_q     <= idx_d;
         len_q     <= len_d;
         wr_en_q   <= wr_en_d;
         wr_pos_q  <= wr_pos_d;
         wr_idx_q  <= wr_idx_d;
         wr_char_q <= wr_char_d;
         done_q    <= done_d;
         err_q     <= err_d;
         code_q    <= code_d;
      end
   end

   cfg_word_assembler #(.NBYTES(SEED_BYTES)) u_seed (
      .clk     (fpgaclk),
      .rst     (reset),
      .clr     (asm_clr),
      .load    (seed_load),
      .byte_in (rx_byte),
      .word    (seed),
      .last    (seed_last)
   );

   cfg_word_assembler #(.NBYTES(GOAL_BYTES)) u_goal (
      .clk     (fpgaclk),
      .rst     (reset),
      .clr     (asm_clr),
      .load    (goal_load),
      .byte_in (rx_byte),
      .word    (goal),
      .last    (goal_last)
   );

   assign wr_en    = wr_en_q;
   assign wr_pos   = wr_pos_q;
   assign wr_idx   = wr_idx_q;
   assign wr_char  = wr_char_q;
   assign len_flat = len_q;
   assign cfg_done = done_q;
   assign cfg_err  = err_q;
   assign err_code = code_q;

endmodule
